mem_access_ctrl: RTL

Downstream consumer of the en/wr/addr command stream produced by the stimulus task. It queues commands into a small FIFO and executes them in order against a 64 x 8 memory. Each access occupies the memory for a programmable number of cycles. Reads return data with a one-cycle valid pulse. Commands that arrive while the queue is full are dropped and flagged.

---
 rtl/mem_access_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// In-order command queue feeding a 64 x DATA_W memory with a programmable access time.
// Optional access statistics are enabled by defining MEM_ACCESS_CTRL_STATS_EN.
module mem_access_ctrl #(
    parameter int FIFO_DEPTH    = 4,
    parameter int ACCESS_CYCLES = 2,
    parameter int DATA_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr,
    input  logic [5:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              full,
    output logic              err
`ifdef MEM_ACCESS_CTRL_STATS_EN
    ,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count,
    output logic [15:0]       drop_count
`endif
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ACC_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int CMD_W = 1 + 6 + DATA_W;
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [ACC_W-1:0] ACC_LOAD = ACC_W'(ACCESS_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;

    logic [CMD_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [ACC_W-1:0]  acc_cnt;
    logic              cmd_wr;
    logic [5:0]        cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] mem [64];

    logic             is_full;
    logic             not_empty;
    logic             push;
    logic             pop;
    logic             done;
    logic [CMD_W-1:0] head;

    // full comes from the pre-edge count, so a push while full is dropped even on a pop edge
    assign is_full   = (count == DEPTH_C);
    assign not_empty = (count != '0);
    assign push      = en && !is_full;
    assign done      = (state == BUSY) && (acc_cnt == '0);
    assign pop       = not_empty && ((state == IDLE) || done);
    assign head      = fifo_mem[rd_ptr];
    assign full      = is_full;
    assign busy      = (state == BUSY);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {wr, addr, wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (!push && pop) begin
                count <= count - (PTR_W + 1)'(1);
            end
        end
    end

    // Access sequencer: a completing access may hand straight over to the next queued command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc_cnt  <= '0;
            cmd_wr   <= 1'b0;
            cmd_addr <= '0;
            cmd_data <= '0;
            rdata    <= '0;
            rvalid   <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            if (done && !cmd_wr) begin
                rdata  <= mem[cmd_addr];
                rvalid <= 1'b1;
            end
            if (pop) begin
                {cmd_wr, cmd_addr, cmd_data} <= head;
                acc_cnt <= ACC_LOAD;
                state   <= BUSY;
            end else if (done) begin
                state <= IDLE;
            end else if (state == BUSY) begin
                acc_cnt <= acc_cnt - ACC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= '0;
            end
        end else if (done && cmd_wr) begin
            mem[cmd_addr] <= cmd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= en && is_full;
        end
    end

`ifdef MEM_ACCESS_CTRL_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count   <= '0;
            rd_count   <= '0;
            drop_count <= '0;
        end else begin
            if (done && cmd_wr) begin
                wr_count <= sat_inc(wr_count);
            end
            if (done && !cmd_wr) begin
                rd_count <= sat_inc(rd_count);
            end
            if (en && is_full) begin
                drop_count <= sat_inc(drop_count);
            end
        end
    end
`endif

endmodule
